// File: rtl/vga_scan_generator.sv
// 640x480@60 VGA raster timing: coordinates, display enable, active-low syncs, frame strobe/counter.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by PIPE_DLY clocks so they line up with mapper RGB.
module vga_scan_generator #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
`ifdef VGA_SYNC_DELAY_EN
    ,
    parameter int unsigned PIPE_DLY  = 2
`endif
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned CW       = 10;
    localparam int unsigned FCW      = 8;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          r_hs;
    logic          r_vs;

    logic w_h_last;
    logic w_v_last;
    logic w_blank;
    logic w_hs;
    logic w_vs;
    logic w_frame_start;

    // Decode the current counter position.
    always_comb begin
        w_h_last      = (r_hc == CW'(H_TOTAL - 1));
        w_v_last      = (r_vc == CW'(V_TOTAL - 1));
        w_blank       = (r_hc < CW'(H_VISIBLE)) && (r_vc < CW'(V_VISIBLE));
        w_hs          = !((r_hc >= CW'(HS_START)) && (r_hc < CW'(HS_END)));
        w_vs          = !((r_vc >= CW'(VS_START)) && (r_vc < CW'(VS_END)));
        w_frame_start = (r_hc == '0) && (r_vc == '0);
    end

    // Raster counters; the line counter advances only on the pixel wrap.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : r_vc + CW'(1);
        end else begin
            r_hc <= r_hc + CW'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= r_hc;
            DrawY       <= r_vc;
            blank       <= w_blank;
            r_hs        <= w_hs;
            r_vs        <= w_vs;
            frame_start <= w_frame_start;
            if (w_frame_start) begin
                frame_count <= frame_count + FCW'(1);
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic [PIPE_DLY-1:0] r_hs_pipe;
    logic [PIPE_DLY-1:0] r_vs_pipe;

    // Sync delay line, idle-high so no false sync pulse follows reset.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_hs_pipe <= '1;
            r_vs_pipe <= '1;
        end else begin
            r_hs_pipe[0] <= r_hs;
            r_vs_pipe[0] <= r_vs;
            for (int i = 1; i < int'(PIPE_DLY); i++) begin
                r_hs_pipe[i] <= r_hs_pipe[i-1];
                r_vs_pipe[i] <= r_vs_pipe[i-1];
            end
        end
    end

    assign hs = r_hs_pipe[PIPE_DLY-1];
    assign vs = r_vs_pipe[PIPE_DLY-1];
`else
    assign hs = r_hs;
    assign vs = r_vs;
`endif

endmodule

// File: tb/tb_vga_scan_generator.sv
// Scoreboarded bench for vga_scan_generator: one full-size instance for line timing,
// one shrunken-timing instance for frame, vsync and frame_count wrap behaviour.
module tb_vga_scan_generator;

`ifdef VGA_SYNC_DELAY_EN
    localparam int PIPE = 2;
`else
    localparam int PIPE = 0;
`endif

    // Shrunken timing: 16 clocks/line, 11 lines/frame, 176 clocks/frame.
    localparam int SHV = 8, SHFP = 2, SHS = 3, SHBP = 3;
    localparam int SVV = 6, SVFP = 1, SVS = 2, SVBP = 2;
    localparam int S_FRAME = (SHV + SHFP + SHS + SHBP) * (SVV + SVFP + SVS + SVBP);

    localparam logic [31:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};

    logic       clk;
    logic       reset;

    logic [9:0] dx_a, dy_a, dx_b, dy_b;
    logic       bl_a, hs_a, vs_a, fs_a;
    logic       bl_b, hs_b, vs_b, fs_b;
    logic [7:0] fc_a, fc_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    vga_scan_generator u_dut (
        .vga_clk(clk), .reset(reset),
        .DrawX(dx_a), .DrawY(dy_a), .blank(bl_a), .hs(hs_a), .vs(vs_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_scan_generator #(
        .H_VISIBLE(SHV), .H_FP(SHFP), .H_SYNC(SHS), .H_BP(SHBP),
        .V_VISIBLE(SVV), .V_FP(SVFP), .V_SYNC(SVS), .V_BP(SVBP)
    ) u_small (
        .vga_clk(clk), .reset(reset),
        .DrawX(dx_b), .DrawY(dy_b), .blank(bl_b), .hs(hs_b), .vs(vs_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected outputs t clocks after reset release, derived from absolute time.
    function automatic logic [31:0] exp_vec(input int t, input int hv, input int hfp, input int hsy,
                                            input int hbp, input int vv, input int vfp,
                                            input int vsy, input int vbp);
        int ht = hv + hfp + hsy + hbp;
        int vt = vv + vfp + vsy + vbp;
        int x  = t % ht;
        int y  = (t / ht) % vt;
        int xp;
        int yp;
        logic       b  = (x < hv) && (y < vv);
        logic       f  = (x == 0) && (y == 0);
        logic       h  = 1'b1;
        logic       v  = 1'b1;
        logic [7:0] fc = 8'(((t / (ht * vt)) + 1) % 256);
        if (t >= PIPE) begin
            xp = (t - PIPE) % ht;
            yp = ((t - PIPE) / ht) % vt;
            h  = !((xp >= hv + hfp) && (xp < hv + hfp + hsy));
            v  = !((yp >= vv + vfp) && (yp < vv + vfp + vsy));
        end
        return {10'(x), 10'(y), b, h, v, f, fc};
    endfunction

    // Reference model: queue what each instance should show after this edge.
    initial begin
        int t = -1;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = -1;
                q_a.push_back(RST_VEC);
                q_b.push_back(RST_VEC);
            end else begin
                t++;
                q_a.push_back(exp_vec(t, 640, 16, 96, 48, 480, 10, 2, 33));
                q_b.push_back(exp_vec(t, SHV, SHFP, SHS, SHBP, SVV, SVFP, SVS, SVBP));
            end
        end
    end

    // Compare both instances every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q_a.size() == 0 || q_b.size() == 0) begin
                check_eq("sb_empty", 32'(q_a.size() + q_b.size()), 32'd2);
            end else begin
                check_eq("sb_full", {dx_a, dy_a, bl_a, hs_a, vs_a, fs_a, fc_a}, q_a.pop_front());
                check_eq("sb_small", {dx_b, dy_b, bl_b, hs_b, vs_b, fs_b, fc_b}, q_b.pop_front());
            end
        end
    end

    initial begin
        int   n_hs   = 0;
        int   n_bl   = 0;
        int   n_vs   = 0;
        int   n_fs   = 0;
        logic found  = 1'b0;

        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_hs_vs", {30'd0, hs_a, vs_a}, 32'd3);
        check_eq("rst_fc", 32'(fc_a), 32'd0);
        reset = 1'b0;

        // First line of the full-size raster.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq("first_xy", {12'd0, dx_a, dy_a}, 32'd0);
                check_eq("first_blank_fs", {30'd0, bl_a, fs_a}, 32'd3);
                check_eq("first_fc", 32'(fc_a), 32'd1);
            end
            if (i == 640) check_eq("blank_fall_640", {31'd0, bl_a}, 32'd0);
            if (i == 656 + PIPE) check_eq("hs_fall", {31'd0, hs_a}, 32'd0);
            if (i == 655 + PIPE) check_eq("hs_pre_fall", {31'd0, hs_a}, 32'd1);
            if (!hs_a) n_hs++;
            if (bl_a) n_bl++;
        end
        check_eq("hs_width", 32'(n_hs), 32'd96);
        check_eq("visible_width", 32'(n_bl), 32'd640);
        @(negedge clk);
        check_eq("line_wrap", {12'd0, dx_a, dy_a}, {12'd0, 10'd0, 10'd1});

        // Mid-frame reset at (300,3).
        for (int i = 0; i < 5000 && !found; i++) begin
            @(negedge clk);
            if (dx_a == 10'd300 && dy_a == 10'd3) found = 1'b1;
        end
        check_eq("reach_300_3", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_vals", {dx_a, dy_a, bl_a, hs_a, vs_a, fs_a, fc_a}, RST_VEC);
        reset = 1'b0;

        // 257 shrunken frames: vsync width, frame pulse count, frame_count wrap.
        for (int i = 0; i < 257 * S_FRAME; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check_eq("restart_xy", {12'd0, dx_a, dy_a}, 32'd0);
                check_eq("restart_fs", {31'd0, fs_a}, 32'd1);
            end
            if (i < S_FRAME && !vs_b) n_vs++;
            if (fs_b) begin
                if (n_fs == 255) check_eq("fc_wrap", 32'(fc_b), 32'd0);
                if (n_fs == 254) check_eq("fc_255", 32'(fc_b), 32'd255);
                n_fs++;
            end
        end
        check_eq("vs_width", 32'(n_vs), 32'(SVS * (SHV + SHFP + SHS + SHBP)));
        check_eq("frame_pulses", 32'(n_fs), 32'd257);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
